prio_req_server: RTL and testbench

PRIO_REQ_SERVER -- requirements
Module: prio_req_server

---
 rtl/prio_req_server_if.sv | 22 ++
 rtl/prio_req_server.sv | 109 ++++++++++
 tb/tb_prio_req_server.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/prio_req_server_if.sv
// Request/offer bundle between a requester-side driver and prio_req_server.
// The master drives raw requests and consumer handshake; the slave returns offer state.
interface prio_req_server_if;
  logic [3:0] req;
  logic       ready;
  logic       clr_ovf;
  logic [3:0] pend;
  logic [1:0] code;
  logic       valid;
  logic       ovf;
  logic [7:0] cnt;

  modport master (
    output req, ready, clr_ovf,
    input  pend, code, valid, ovf, cnt
  );

  modport slave (
    input  req, ready, clr_ovf,
    output pend, code, valid, ovf, cnt
  );
endinterface

// File: rtl/prio_req_server.sv
// Captures request lines into a sticky pending vector and serves them one at a time,
// highest index first, with a mandatory idle cycle after every accepted offer.
module prio_req_server #(
  parameter int unsigned EDGE = 1
) (
  input  logic                clk,
  input  logic                rst,
  prio_req_server_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] req_q;
  logic [3:0] pend_q, pend_d;
  logic [1:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       ovf_q, ovf_d;
  logic [7:0] cnt_q, cnt_d;

  logic [3:0] cap;
  logic [3:0] clr;
  logic       accept;
  logic       ovf_set;

  function automatic logic [1:0] prio_enc(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    if (v[3])      idx = 2'd3;
    else if (v[2]) idx = 2'd2;
    else if (v[1]) idx = 2'd1;
    else           idx = 2'd0;
    return idx;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Capture, pending update and overflow detection
  always_comb begin
    cap     = (EDGE != 0) ? (bus.req & ~req_q) : bus.req;
    accept  = (state_q == OFFER) && bus.ready;
    clr     = accept ? onehot(code_q) : 4'b0000;
    // A fresh capture on the bit being cleared re-arms it rather than overflowing.
    pend_d  = (pend_q & ~clr) | cap;
    ovf_set = |(cap & pend_q & ~clr);
    ovf_d   = ovf_set | (ovf_q & ~bus.clr_ovf);
    cnt_d   = accept ? (cnt_q + 8'd1) : cnt_q;
  end

  // Offer sequencing; decisions use the registered pending vector
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      IDLE: begin
        if (pend_q != 4'b0000) begin
          state_d = OFFER;
          code_d  = prio_enc(pend_q);
        end
      end
      OFFER: begin
        if (bus.ready) state_d = GAP;
      end
      GAP: begin
        if (pend_q != 4'b0000) begin
          state_d = OFFER;
          code_d  = prio_enc(pend_q);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == OFFER);
  end

  // Register stage; req_q keeps tracking req through reset so a held level is no edge
  always_ff @(posedge clk) begin
    req_q <= bus.req;
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= 4'b0000;
      code_q  <= 2'd0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pend  = pend_q;
  assign bus.code  = code_q;
  assign bus.valid = valid_q;
  assign bus.ovf   = ovf_q;
  assign bus.cnt   = cnt_q;

endmodule

// File: tb/tb_prio_req_server.sv
// Directed and randomized bench for prio_req_server against a behavioural model
// that tracks pending requests as a set and the current offer as a single flag.
module tb_prio_req_server;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prio_req_server_if bus();

  prio_req_server #(.EDGE(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [3:0] m_pend = 4'b0;
  logic [3:0] m_prev = 4'b0;
  bit         m_offer = 1'b0;
  logic [1:0] m_code = 2'd0;
  bit         m_ovf = 1'b0;
  logic [7:0] m_cnt = 8'd0;

  function automatic int top_bit(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_update();
    logic [3:0] cap, clr;
    bit         accept;
    if (rst) begin
      m_pend  = 4'b0;
      m_offer = 1'b0;
      m_code  = 2'd0;
      m_ovf   = 1'b0;
      m_cnt   = 8'd0;
      m_prev  = bus.req;
    end else begin
      cap    = bus.req & ~m_prev;
      m_prev = bus.req;
      accept = m_offer && bus.ready;
      clr    = accept ? (4'b0001 << m_code) : 4'b0000;
      if (m_offer) begin
        if (accept) begin
          m_offer = 1'b0;
          m_cnt   = m_cnt + 8'd1;
        end
      end else if (m_pend != 4'b0) begin
        // idle or post-accept gap: next offer picks the top pending bit
        m_offer = 1'b1;
        m_code  = 2'(top_bit(m_pend));
      end
      m_ovf  = (|(cap & m_pend & ~clr)) | (m_ovf & ~bus.clr_ovf);
      m_pend = (m_pend & ~clr) | cap;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    chk("pend",  8'(bus.pend),  8'(m_pend));
    chk("code",  8'(bus.code),  8'(m_offer ? m_code : bus.code));
    chk("valid", 8'(bus.valid), 8'(m_offer));
    chk("ovf",   8'(bus.ovf),   8'(m_ovf));
    chk("cnt",   bus.cnt,       m_cnt);
  endtask

  initial begin
    rst         = 1'b1;
    bus.req     = 4'b0;
    bus.ready   = 1'b0;
    bus.clr_ovf = 1'b0;
    tick();
    tick();
    chk("rst_code", 8'(bus.code), 8'd0);
    chk("rst_cnt", bus.cnt, 8'd0);
    rst = 1'b0;
    tick();

    // single low-priority pulse, consumer always ready
    bus.ready = 1'b1;
    bus.req = 4'b0001; tick();
    chk("r26_pend", 8'(bus.pend), 8'h1);
    chk("r26_nvalid", 8'(bus.valid), 8'd0);
    bus.req = 4'b0000; tick();
    chk("r26_valid", 8'(bus.valid), 8'd1);
    chk("r26_code", 8'(bus.code), 8'd0);
    tick();
    chk("r26_pend0", 8'(bus.pend), 8'h0);
    chk("r26_cnt", bus.cnt, 8'd1);
    tick();
    chk("r26_idle", 8'(bus.valid), 8'd0);

    // all four at once: served 3,2,1,0 with a gap between each
    bus.req = 4'b1111; tick();
    chk("r27_pend", 8'(bus.pend), 8'hF);
    bus.req = 4'b0000;
    for (int i = 3; i >= 0; i--) begin
      tick();
      chk("r27_valid", 8'(bus.valid), 8'd1);
      chk("r27_code", 8'(bus.code), 8'(i));
      tick();
      chk("r27_gap", 8'(bus.valid), 8'd0);
    end
    chk("r27_cnt", bus.cnt, 8'd5);
    chk("r27_ovf", 8'(bus.ovf), 8'd0);

    // a higher request must not preempt a stalled offer
    bus.ready = 1'b0;
    bus.req = 4'b0010; tick();
    bus.req = 4'b0000; tick();
    chk("r28_code1", 8'(bus.code), 8'd1);
    bus.req = 4'b1000; tick();
    bus.req = 4'b0000; tick();
    chk("r28_hold", 8'(bus.code), 8'd1);
    chk("r28_pend", 8'(bus.pend), 8'hA);
    bus.ready = 1'b1; tick();
    chk("r28_gap", 8'(bus.valid), 8'd0);
    bus.ready = 1'b0; tick();
    chk("r28_code3", 8'(bus.code), 8'd3);
    chk("r28_valid", 8'(bus.valid), 8'd1);
    bus.ready = 1'b1; tick(); tick();

    // second pulse on an unserved bit sets sticky overflow
    bus.ready = 1'b0;
    bus.req = 4'b0100; tick();
    bus.req = 4'b0000; tick();
    bus.req = 4'b0100; tick();
    chk("r29_ovf", 8'(bus.ovf), 8'd1);
    bus.req = 4'b0000; tick(); tick();
    chk("r29_sticky", 8'(bus.ovf), 8'd1);
    bus.clr_ovf = 1'b1; tick();
    chk("r29_clr", 8'(bus.ovf), 8'd0);
    bus.clr_ovf = 1'b0; tick();
    bus.ready = 1'b1; tick(); tick(); tick();
    chk("r29_cnt", bus.cnt, 8'd8);

    // re-capture of the bit being accepted
    bus.ready = 1'b0;
    bus.req = 4'b0010; tick();
    bus.req = 4'b0000; tick();
    bus.ready = 1'b1;
    bus.req = 4'b0010; tick();
    chk("r30_pend", 8'(bus.pend), 8'h2);
    chk("r30_ovf", 8'(bus.ovf), 8'd0);
    chk("r30_gap", 8'(bus.valid), 8'd0);
    bus.req = 4'b0000; tick();
    chk("r30_reoffer", 8'(bus.code), 8'd1);
    chk("r30_valid", 8'(bus.valid), 8'd1);
    tick(); tick();

    // reset mid-offer with a level held across reset
    bus.ready = 1'b0;
    bus.req = 4'b0001; tick();
    bus.req = 4'b0000; tick();
    bus.req = 4'b0100; rst = 1'b1; tick();
    chk("r25_valid", 8'(bus.valid), 8'd0);
    chk("r25_cnt", bus.cnt, 8'd0);
    tick();
    rst = 1'b0; tick(); tick();
    chk("r31_pend", 8'(bus.pend), 8'h0);
    bus.req = 4'b0000; tick();

    // counter wrap
    bus.ready = 1'b1;
    for (int n = 0; n < 255; n++) begin
      bus.req = 4'b0001; tick();
      bus.req = 4'b0000; tick(); tick(); tick();
    end
    chk("r31_cnt255", bus.cnt, 8'hFF);
    bus.req = 4'b0001; tick();
    bus.req = 4'b0000; tick(); tick(); tick();
    chk("r31_wrap", bus.cnt, 8'h00);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      bus.req     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      bus.ready   = 1'($urandom_range(0, 1));
      bus.clr_ovf = ($urandom_range(0, 7) == 0);
      rst         = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
